// File: rtl/tilt_uart_framer_if.sv
// rtl/tilt_uart_framer_if.sv - byte send handshake between the tilt framer and the UART transmitter
interface tilt_uart_framer_if;
  logic       send;
  logic [7:0] send_data;
  logic       uart_ready;

  modport master (output send, output send_data, input uart_ready);
  modport slave  (input send, input send_data, output uart_ready);
endinterface

// File: rtl/tilt_uart_framer.sv
// rtl/tilt_uart_framer.sv - classifies gyro Y/Z tilt with hysteresis and paces HDR/LR/TB frames to a UART
// Optional TILT_MAG_EN appends a saturated magnitude byte after each direction byte.
module tilt_uart_framer #(
  parameter int         DATA_W    = 16,
  parameter int         THRESH    = 4096,
  parameter int         HYST      = 1024,
  parameter logic [7:0] HDR_BYTE  = 8'h63,
  parameter logic [7:0] NEUTRAL   = 8'hFF,
  parameter int         MAG_SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic signed [DATA_W-1:0] data_x,
  input  logic signed [DATA_W-1:0] data_y,
  input  logic signed [DATA_W-1:0] data_z,
  tilt_uart_framer_if.master       uart,
  output logic                     frame_busy,
  output logic [3:0]               dir,
  output logic                     overrun,
  output logic signed [DATA_W-1:0] dbg_axis
);

`ifdef TILT_MAG_EN
  localparam int N_BYTES = 5;
`else
  localparam int N_BYTES = 3;
`endif
  localparam logic [2:0] LAST_IDX = 3'(N_BYTES - 1);
  localparam logic signed [DATA_W:0] T_SET = (DATA_W+1)'(THRESH);
  localparam logic signed [DATA_W:0] T_REL = (DATA_W+1)'(THRESH - HYST);

  typedef enum logic [2:0] {S_IDLE, S_CLASSIFY, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic                      send_q, send_d;
  logic [7:0]                data_q, data_d;
  logic                      busy_d, overrun_d, snap;
  logic [3:0]                dir_d;
  logic signed [DATA_W-1:0]  x_s, y_s, z_s;
  logic signed [DATA_W:0]    y_w, z_w;
  logic [7:0]                lr_byte, tb_byte, cur_byte;

  // Widening by one bit keeps -(most negative sample) representable.
  assign y_w = {y_s[DATA_W-1], y_s};
  assign z_w = {z_s[DATA_W-1], z_s};

  // Returns {neg, pos}; entering one side clears the other, release only below THRESH-HYST.
  function automatic logic [1:0] classify(input logic signed [DATA_W:0] v,
                                          input logic neg_f, input logic pos_f);
    logic n, p;
    n = neg_f;
    p = pos_f;
    if (v < -T_SET) begin
      n = 1'b1;
      p = 1'b0;
    end else if (v > T_SET) begin
      p = 1'b1;
      n = 1'b0;
    end else begin
      if (v > -T_REL) n = 1'b0;
      if (v < T_REL)  p = 1'b0;
    end
    return {n, p};
  endfunction

`ifdef TILT_MAG_EN
  localparam logic [DATA_W:0] MAG_CAP = (DATA_W+1)'(254);

  function automatic logic [7:0] mag_byte(input logic signed [DATA_W:0] v);
    logic [DATA_W:0] a, s;
    a = v[DATA_W] ? $unsigned(-v) : $unsigned(v);
    s = a >> MAG_SHIFT;
    return (s > MAG_CAP) ? 8'hFE : s[7:0];
  endfunction
`endif

  assign lr_byte = dir[3] ? 8'h02 : (dir[2] ? 8'h03 : NEUTRAL);
  assign tb_byte = dir[1] ? 8'h00 : (dir[0] ? 8'h01 : NEUTRAL);

  always_comb begin
    cur_byte = HDR_BYTE;
    case (idx_q)
      3'd1:    cur_byte = lr_byte;
`ifdef TILT_MAG_EN
      3'd2:    cur_byte = mag_byte(y_w);
      3'd3:    cur_byte = tb_byte;
      3'd4:    cur_byte = mag_byte(z_w);
`else
      3'd2:    cur_byte = tb_byte;
`endif
      default: cur_byte = HDR_BYTE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    send_d    = 1'b0;
    data_d    = data_q;
    busy_d    = frame_busy;
    dir_d     = dir;
    overrun_d = overrun;
    snap      = 1'b0;
    if (tick && state_q != S_IDLE) overrun_d = 1'b1;
    case (state_q)
      S_IDLE: if (tick) begin
        snap    = 1'b1;
        idx_d   = 3'd0;
        state_d = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        dir_d   = {classify(y_w, dir[3], dir[2]), classify(z_w, dir[1], dir[0])};
        state_d = S_ISSUE;
      end
      S_ISSUE: if (uart.uart_ready) begin
        send_d  = 1'b1;
        data_d  = cur_byte;
        busy_d  = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!uart.uart_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (uart.uart_ready) begin
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      send_q     <= 1'b0;
      data_q     <= 8'h00;
      frame_busy <= 1'b0;
      dir        <= 4'b0000;
      overrun    <= 1'b0;
      x_s        <= '0;
      y_s        <= '0;
      z_s        <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      send_q     <= send_d;
      data_q     <= data_d;
      frame_busy <= busy_d;
      dir        <= dir_d;
      overrun    <= overrun_d;
      if (snap) begin
        x_s <= data_x;
        y_s <= data_y;
        z_s <= data_z;
      end
    end
  end

  assign uart.send      = send_q;
  assign uart.send_data = data_q;
  assign dbg_axis       = x_s;

endmodule

// File: tb/tb_tilt_uart_framer.sv
// tb/tb_tilt_uart_framer.sv - directed self-checking bench for tilt_uart_framer
module tb_tilt_uart_framer;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tick = 1'b0;
  logic signed [15:0] data_x = '0;
  logic signed [15:0] data_y = '0;
  logic signed [15:0] data_z = '0;
  logic               frame_busy;
  logic [3:0]         dir;
  logic               overrun;
  logic signed [15:0] dbg_axis;
  int                 vecs = 0;
  int                 miss = 0;

  tilt_uart_framer_if u_if ();

  tilt_uart_framer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .data_x     (data_x),
    .data_y     (data_y),
    .data_z     (data_z),
    .uart       (u_if),
    .frame_busy (frame_busy),
    .dir        (dir),
    .overrun    (overrun),
    .dbg_axis   (dbg_axis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Acts as the UART: waits for a send, checks it, then runs a ready low/high cycle.
  task automatic expect_byte(input string tag, input logic [7:0] exp, input bit stall,
                             output int waited);
    bit seen;
    int extra;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < 64) begin
      @(negedge clk);
      waited++;
      if (u_if.send) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk(tag, 32'(u_if.send_data), 32'(exp));
      chk({tag, "_busy"}, 32'(frame_busy), 32'd1);
      if (stall) begin
        extra = 0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (u_if.send) extra++;
        end
        chk({tag, "_stall"}, 32'(extra), 32'd0);
      end
      u_if.uart_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_1cyc"}, 32'(u_if.send), 32'd0);
      @(negedge clk);
      @(negedge clk);
      u_if.uart_ready = 1'b1;
    end
  endtask

  task automatic finish_frame(input string tag);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(frame_busy), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic signed [15:0] y, input logic signed [15:0] z,
                           input logic [7:0] lr, input logic [7:0] lrm,
                           input logic [7:0] tb, input logic [7:0] tbm);
    int w;
    data_y = y;
    data_z = z;
    pulse_tick();
    expect_byte({tag, "_hdr"}, 8'h63, 1'b0, w);
    expect_byte({tag, "_lr"}, lr, 1'b0, w);
`ifdef TILT_MAG_EN
    expect_byte({tag, "_lrmag"}, lrm, 1'b0, w);
`endif
    expect_byte({tag, "_tb"}, tb, 1'b0, w);
`ifdef TILT_MAG_EN
    expect_byte({tag, "_tbmag"}, tbm, 1'b0, w);
`endif
    finish_frame(tag);
  endtask

  initial begin
    int w;
    int sends;
    u_if.uart_ready = 1'b1;

    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
    chk("rst_send", 32'(u_if.send), 32'd0);
    chk("rst_data", 32'(u_if.send_data), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(frame_busy), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    data_x = 16'sh1234;
    data_y = -16'sd5000;
    data_z = 16'sd0;
    pulse_tick();
    chk("dbg_axis", 32'(dbg_axis), 32'h1234);
    chk("lat_early", 32'(u_if.send), 32'd0);
    expect_byte("f1_hdr", 8'h63, 1'b0, w);
    chk("lat_header", 32'(w), 32'd2);
    expect_byte("f1_lr", 8'h02, 1'b0, w);
`ifdef TILT_MAG_EN
    expect_byte("f1_lrmag", 8'h13, 1'b0, w);
`endif
    expect_byte("f1_tb", 8'hFF, 1'b0, w);
`ifdef TILT_MAG_EN
    expect_byte("f1_tbmag", 8'h00, 1'b0, w);
`endif
    finish_frame("f1");
    chk("f1_dir", 32'(dir), 32'b1000);

    run_frame("hy_3500", -16'sd3500, 16'sd0, 8'h02, 8'h0D, 8'hFF, 8'h00);
    run_frame("hy_2900", -16'sd2900, 16'sd0, 8'hFF, 8'h0B, 8'hFF, 8'h00);
    run_frame("hy_4096", 16'sd4096, 16'sd0, 8'hFF, 8'h10, 8'hFF, 8'h00);
    run_frame("hy_4097", 16'sd4097, 16'sd0, 8'h03, 8'h10, 8'hFF, 8'h00);
    chk("hy_dir", 32'(dir), 32'b0100);
    run_frame("minneg", 16'sh8000, 16'sh0100, 8'h02, 8'h80, 8'hFF, 8'h01);
    chk("minneg_dir", 32'(dir), 32'b1000);

    u_if.uart_ready = 1'b0;
    data_y = 16'sd0;
    data_z = 16'sd5000;
    pulse_tick();
    sends = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.send) sends++;
    end
    chk("hs_hold", 32'(sends), 32'd0);
    u_if.uart_ready = 1'b1;
    expect_byte("hs_hdr", 8'h63, 1'b1, w);
    expect_byte("hs_lr", 8'hFF, 1'b1, w);
`ifdef TILT_MAG_EN
    expect_byte("hs_lrmag", 8'h00, 1'b0, w);
`endif
    expect_byte("hs_tb", 8'h01, 1'b0, w);
`ifdef TILT_MAG_EN
    expect_byte("hs_tbmag", 8'h13, 1'b0, w);
`endif
    finish_frame("hs");
    chk("hs_dir", 32'(dir), 32'b0001);
    chk("hs_no_overrun", 32'(overrun), 32'd0);

    data_y = -16'sd5000;
    data_z = -16'sd5000;
    pulse_tick();
    expect_byte("ov_hdr", 8'h63, 1'b0, w);
    data_y = 16'sd5000;
    data_z = 16'sd5000;
    pulse_tick();
    chk("ov_flag", 32'(overrun), 32'd1);
    expect_byte("ov_lr", 8'h02, 1'b0, w);
`ifdef TILT_MAG_EN
    expect_byte("ov_lrmag", 8'h13, 1'b0, w);
`endif
    expect_byte("ov_tb", 8'h00, 1'b0, w);
`ifdef TILT_MAG_EN
    expect_byte("ov_tbmag", 8'h13, 1'b0, w);
`endif
    finish_frame("ov");
    chk("ov_dir", 32'(dir), 32'b1010);
    chk("ov_sticky", 32'(overrun), 32'd1);

    data_y = 16'sd5000;
    data_z = 16'sd0;
    pulse_tick();
    expect_byte("rm_hdr", 8'h63, 1'b0, w);
    expect_byte("rm_lr", 8'h03, 1'b0, w);
    rst_n = 1'b0;
    #1;
    chk("rm_send", 32'(u_if.send), 32'd0);
    chk("rm_data", 32'(u_if.send_data), 32'd0);
    chk("rm_dir", 32'(dir), 32'd0);
    chk("rm_busy", 32'(frame_busy), 32'd0);
    chk("rm_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sends = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (u_if.send) sends++;
    end
    chk("rm_quiet", 32'(sends), 32'd0);
    run_frame("rm_next", 16'sd0, -16'sd5000, 8'hFF, 8'h00, 8'h00, 8'h13);
    chk("rm_next_dir", 32'(dir), 32'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
